// File: rtl/gte_pkg.sv
// Shared widths, flag layout, IR limits and sequencer state for the GTE MVMVA sequencer.
package gte_pkg;

   localparam int ACC_W           = 48;
   localparam int MAC_CHK_W       = 44;
   localparam int IR_W            = 16;

   localparam int MAC_POS_OVF_LSB = 0;
   localparam int MAC_NEG_OVF_LSB = 3;
   localparam int IR_SAT_LSB      = 6;

   localparam logic signed [31:0] IR_MAX = 32'sh0000_7FFF;
   localparam logic signed [31:0] IR_MIN = -32'sh0000_8000;

   typedef enum logic {IDLE, RUN} state_t;

   // TR is a 32-bit value placed at bit 12 of the accumulator, sign-extended to ACC_W.
   function automatic logic [ACC_W-1:0] tr_to_acc(input logic [31:0] tr_val);
      return {{(ACC_W-44){tr_val[31]}}, tr_val, 12'h000};
   endfunction

endpackage

// File: rtl/gte_mac_lane.sv
// One row's result stage: optional >>12, truncation to 32-bit MAC, and IR clamp with saturation flag.
module gte_mac_lane
   import gte_pkg::*;
(
   input  logic [MAC_CHK_W-1:0] sum_i,
   input  logic                 sf_i,
   input  logic                 lm_i,
   output logic [31:0]          mac_o,
   output logic [IR_W-1:0]      ir_o,
   output logic                 sat_o
);

   logic signed [31:0] mac_s;
   logic signed [31:0] lo_s;

   always_comb begin
      // Arithmetic >>12 followed by [31:0] is exactly bits [43:12].
      mac_s = sf_i ? sum_i[43:12] : sum_i[31:0];
      lo_s  = lm_i ? 32'sd0 : IR_MIN;
      sat_o = 1'b0;
      ir_o  = mac_s[IR_W-1:0];
      if (mac_s > IR_MAX) begin
         ir_o  = IR_MAX[IR_W-1:0];
         sat_o = 1'b1;
      end else if (mac_s < lo_s) begin
         ir_o  = lo_s[IR_W-1:0];
         sat_o = 1'b1;
      end
   end

   assign mac_o = mac_s;

endmodule

// File: rtl/gte_mvmva_seq.sv
// MVMVA sequencer: drives one MULTALU term per step (row r, term t) and collects MAC/IR/flags.
// Optional GTE_MAC_PIPE_EN registers mac_dout internally, making each term an issue+capture pair.
module gte_mvmva_seq
   import gte_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sf,
   input  logic             lm,
   input  logic [143:0]     mtx,
   input  logic [47:0]      vec,
   input  logic [95:0]      tr,
   output logic [26:0]      mac_a,
   output logic [17:0]      mac_b,
   output logic [ACC_W-1:0] mac_c,
   output logic             mac_addsub1,
   output logic             mac_addsub0,
   input  logic [ACC_W-1:0] mac_dout,
   output logic             busy,
   output logic             done,
   output logic [95:0]      mac_out,
   output logic [47:0]      ir_out,
   output logic [8:0]       flags
);

   state_t           state_q, state_d;
   logic [1:0]       r_q, r_d, t_q, t_d;
   logic             done_q, done_d;
   logic [26:0]      mac_a_q, mac_a_d;
   logic [17:0]      mac_b_q, mac_b_d;
   logic [ACC_W-1:0] mac_c_q, mac_c_d;
   logic [31:0]      mac_q [3];
   logic [31:0]      mac_d [3];
   logic [IR_W-1:0]  ir_q [3];
   logic [IR_W-1:0]  ir_d [3];
   logic [2:0]       pos_q, pos_d, neg_q, neg_d, sat_q, sat_d;

   logic [143:0]     mtx_q;
   logic [47:0]      vec_q;
   logic [95:0]      tr_q;
   logic             sf_q, lm_q;

   logic             ld;
   logic             cap_en;
   logic [ACC_W-1:0] cap_val;
   logic             chk_ovf;
   logic [15:0]      m_el [9];
   logic [15:0]      v_el [3];
   logic [31:0]      tr_el [3];
   logic [3:0]       mi;
   logic [31:0]      lane_mac;
   logic [IR_W-1:0]  lane_ir;
   logic             lane_sat;

`ifdef GTE_MAC_PIPE_EN
   logic             ph_q, ph_d;
   logic [ACC_W-1:0] dout_q;

   assign cap_en  = (state_q == RUN) && ph_q;
   assign cap_val = dout_q;
`else
   assign cap_en  = (state_q == RUN);
   assign cap_val = mac_dout;
`endif

   assign ld      = (state_q == IDLE) && start;
   assign chk_ovf = !((&cap_val[ACC_W-1:MAC_CHK_W-1]) || !(|cap_val[ACC_W-1:MAC_CHK_W-1]));

   // The first term's operands come straight from the inputs, since they are latched on the same edge.
   always_comb begin
      for (int k = 0; k < 9; k++) m_el[k] = ld ? mtx[16*k +: 16] : mtx_q[16*k +: 16];
      for (int k = 0; k < 3; k++) v_el[k] = ld ? vec[16*k +: 16] : vec_q[16*k +: 16];
      for (int k = 0; k < 3; k++) tr_el[k] = ld ? tr[32*k +: 32] : tr_q[32*k +: 32];
   end

   gte_mac_lane u_lane (
      .sum_i (cap_val[MAC_CHK_W-1:0]),
      .sf_i  (sf_q),
      .lm_i  (lm_q),
      .mac_o (lane_mac),
      .ir_o  (lane_ir),
      .sat_o (lane_sat)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      t_d     = t_q;
      done_d  = 1'b0;
      mac_a_d = mac_a_q;
      mac_b_d = mac_b_q;
      mac_c_d = mac_c_q;
      mac_d   = mac_q;
      ir_d    = ir_q;
      pos_d   = pos_q;
      neg_d   = neg_q;
      sat_d   = sat_q;
      mi      = 4'd0;
`ifdef GTE_MAC_PIPE_EN
      ph_d    = ph_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               r_d     = 2'd0;
               t_d     = 2'd0;
               pos_d   = 3'b000;
               neg_d   = 3'b000;
               sat_d   = 3'b000;
`ifdef GTE_MAC_PIPE_EN
               ph_d    = 1'b0;
`endif
            end
         end
         RUN: begin
`ifdef GTE_MAC_PIPE_EN
            ph_d = ~ph_q;
`endif
            if (cap_en) begin
               if (chk_ovf) begin
                  if (cap_val[ACC_W-1]) neg_d[r_q] = 1'b1;
                  else                  pos_d[r_q] = 1'b1;
               end
               if (t_q == 2'd2) begin
                  mac_d[r_q] = lane_mac;
                  ir_d[r_q]  = lane_ir;
                  if (lane_sat) sat_d[r_q] = 1'b1;
                  t_d = 2'd0;
                  if (r_q == 2'd2) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     r_d = r_q + 2'd1;
                  end
               end else begin
                  t_d = t_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Operands only move on accept or capture, so they stay stable through a pipelined issue cycle.
      if (ld || cap_en) begin
         if (state_d == RUN) begin
            mi      = ({2'b00, r_d} * 4'd3) + {2'b00, t_d};
            mac_a_d = {{11{m_el[mi][15]}}, m_el[mi]};
            mac_b_d = {{2{v_el[t_d][15]}}, v_el[t_d]};
            mac_c_d = (t_d == 2'd0) ? tr_to_acc(tr_el[r_d]) : cap_val;
         end else begin
            mac_a_d = '0;
            mac_b_d = '0;
            mac_c_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         r_q     <= 2'd0;
         t_q     <= 2'd0;
         done_q  <= 1'b0;
         mac_a_q <= '0;
         mac_b_q <= '0;
         mac_c_q <= '0;
         pos_q   <= 3'b000;
         neg_q   <= 3'b000;
         sat_q   <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            mac_q[k] <= '0;
            ir_q[k]  <= '0;
         end
`ifdef GTE_MAC_PIPE_EN
         ph_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         t_q     <= t_d;
         done_q  <= done_d;
         mac_a_q <= mac_a_d;
         mac_b_q <= mac_b_d;
         mac_c_q <= mac_c_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
         sat_q   <= sat_d;
         mac_q   <= mac_d;
         ir_q    <= ir_d;
`ifdef GTE_MAC_PIPE_EN
         ph_q    <= ph_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (ld) begin
         mtx_q <= mtx;
         vec_q <= vec;
         tr_q  <= tr;
         sf_q  <= sf;
         lm_q  <= lm;
      end
`ifdef GTE_MAC_PIPE_EN
      dout_q <= mac_dout;
`endif
   end

   assign mac_a       = mac_a_q;
   assign mac_b       = mac_b_q;
   assign mac_c       = mac_c_q;
   assign mac_addsub1 = 1'b0;
   assign mac_addsub0 = 1'b0;
   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign mac_out     = {mac_q[2], mac_q[1], mac_q[0]};
   assign ir_out      = {ir_q[2], ir_q[1], ir_q[0]};
   assign flags[MAC_POS_OVF_LSB +: 3] = pos_q;
   assign flags[MAC_NEG_OVF_LSB +: 3] = neg_q;
   assign flags[IR_SAT_LSB +: 3]      = sat_q;

endmodule

// File: tb/tb_gte_mvmva_seq.sv
// Randomized + directed bench for gte_mvmva_seq with an integer-arithmetic reference model and MULTALU model.
module tb_gte_mvmva_seq;

   logic         clk, reset, start, sf, lm;
   logic [143:0] mtx;
   logic [47:0]  vec;
   logic [95:0]  tr;
   logic [26:0]  mac_a;
   logic [17:0]  mac_b;
   logic [47:0]  mac_c, mac_dout;
   logic         mac_addsub1, mac_addsub0, busy, done;
   logic [95:0]  mac_out;
   logic [47:0]  ir_out;
   logic [8:0]   flags;

   int n_chk  = 0;
   int n_fail = 0;
   bit in_done = 1'b0;

`ifdef GTE_MAC_PIPE_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 9;
`endif
   localparam longint LIM_P = (64'sd1 <<< 43) - 64'sd1;
   localparam longint LIM_N = -(64'sd1 <<< 43);

   gte_mvmva_seq dut (
      .clk(clk), .reset(reset), .start(start), .sf(sf), .lm(lm),
      .mtx(mtx), .vec(vec), .tr(tr),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
      .mac_addsub1(mac_addsub1), .mac_addsub0(mac_addsub0),
      .mac_dout(mac_dout), .busy(busy), .done(done),
      .mac_out(mac_out), .ir_out(ir_out), .flags(flags)
   );

   // Combinational MULTALU: c + a*b
   assign mac_dout = $signed(mac_c) + $signed(mac_a) * $signed(mac_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [143:0] m9(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
      return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [143:0] rnd_m(input int mode);
      logic [143:0] x;
      for (int i = 0; i < 9; i++)
         x[16*i +: 16] = (mode == 0) ? 16'($urandom()) : 16'($urandom_range(0, 511)) - 16'd256;
      return x;
   endfunction

   function automatic logic [31:0] rnd_tr();
      case ($urandom_range(0, 3))
         0: return 32'h0;
         1: return 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
         2: return 32'h8000_0000 + 32'($urandom_range(0, 3));
         default: return 32'($urandom());
      endcase
   endfunction

   task automatic model(input logic [143:0] m, input logic [47:0] v, input logic [95:0] t,
                        input logic s, input logic l,
                        output logic [95:0] em, output logic [47:0] ei, output logic [8:0] ef);
      longint acc, res, lo;
      logic signed [31:0] mc;
      em = '0; ei = '0; ef = '0;
      for (int r = 0; r < 3; r++) begin
         acc = longint'($signed(t[32*r +: 32])) * 64'sd4096;
         for (int j = 0; j < 3; j++) begin
            acc += longint'($signed(m[16*(3*r+j) +: 16])) * longint'($signed(v[16*j +: 16]));
            if (acc > LIM_P) ef[r] = 1'b1;
            else if (acc < LIM_N) ef[3+r] = 1'b1;
         end
         res = s ? (acc >>> 12) : acc;
         mc  = res[31:0];
         em[32*r +: 32] = mc;
         lo = l ? 64'sd0 : -64'sd32768;
         if (longint'(mc) > 64'sd32767) begin
            ei[16*r +: 16] = 16'h7FFF; ef[6+r] = 1'b1;
         end else if (longint'(mc) < lo) begin
            ei[16*r +: 16] = 16'(lo); ef[6+r] = 1'b1;
         end else begin
            ei[16*r +: 16] = mc[15:0];
         end
      end
   endtask

   task automatic run_op(input logic [143:0] m, input logic [47:0] v, input logic [95:0] t,
                         input logic s, input logic l, input int inj, input bit stay);
      logic [95:0] em;
      logic [47:0] ei;
      logic [8:0]  ef;
      int k;
      bit got;
      model(m, v, t, s, l, em, ei, ef);
      if (!in_done) @(negedge clk);
      in_done = 1'b0;
      mtx = m; vec = v; tr = t; sf = s; lm = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mtx = rnd_m(0); vec = {16'($urandom()), 16'($urandom()), 16'($urandom())};
      tr = {32'($urandom()), 32'($urandom()), 32'($urandom())}; sf = ~s; lm = ~l;
      check("busy_run", 128'(busy), 128'(1));
      check("addsub", 128'({mac_addsub1, mac_addsub0}), 128'(0));
      k = 0; got = 1'b0;
      while (!got && k < 4*LAT) begin
         start = (k == inj);
         @(negedge clk);
         k++;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      check("latency", 128'(k), 128'(LAT));
      check("busy_at_done", 128'(busy), 128'(0));
      check("mac_out", 128'(mac_out), 128'(em));
      check("ir_out", 128'(ir_out), 128'(ei));
      check("flags", 128'(flags), 128'(ef));
      if (stay) in_done = 1'b1;
      else begin
         @(negedge clk);
         check("done_pulse", 128'(done), 128'(0));
      end
   endtask

   logic [143:0] id_m;
   logic [47:0]  id_v;

   initial begin
      reset = 1'b1; start = 1'b0; sf = 1'b0; lm = 1'b0; mtx = '0; vec = '0; tr = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_outs", 128'({mac_out, ir_out, flags}), 128'(0));
      check("rst_ops", 128'({mac_a, mac_b, mac_c}), 128'(0));
      reset = 1'b0;

      id_m = m9(16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 16'h1000);
      id_v = {-16'sh300, 16'h200, 16'h100};
      run_op(id_m, id_v, 96'h0, 1'b1, 1'b0, -1, 1'b0);
      check("id_mac", 128'(mac_out), 128'({-32'sh300, 32'h200, 32'h100}));
      check("id_flags", 128'(flags), 128'(0));

      run_op(m9(-16'sh1000, 0, 0, 0, 0, 0, 0, 0, 0), 48'h100, 96'h0, 1'b1, 1'b1, -1, 1'b0);
      check("neg_lm1_ir1", 128'(ir_out[15:0]), 128'(0));
      check("neg_lm1_sat", 128'(flags), 128'(9'h040));
      run_op(m9(-16'sh1000, 0, 0, 0, 0, 0, 0, 0, 0), 48'h100, 96'h0, 1'b1, 1'b0, -1, 1'b0);
      check("neg_lm0_ir1", 128'(ir_out[15:0]), 128'(16'hFF00));

      run_op(m9(16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0, 0), {16'h0, 16'h7FFF, 16'h7FFF}, 96'h0,
             1'b0, 1'b0, -1, 1'b0);
      check("big_mac1", 128'(mac_out[31:0]), 128'(32'h7FFE_0002));
      check("big_flags", 128'(flags), 128'(9'h040));

      run_op(m9(16'h7FFF, 0, 0, 0, 0, 0, 0, 0, 0), 48'h7FFF, 96'h7FFF_FFFF, 1'b0, 1'b0, -1, 1'b0);
      check("pos_ovf", 128'(flags[0]), 128'(1));
      run_op(m9(16'h7FFF, 0, 0, 0, 0, 0, 0, 0, 0), {32'h0, -16'sh7FFF}, 96'h8000_0000,
             1'b0, 1'b0, -1, 1'b0);
      check("neg_ovf", 128'(flags[3]), 128'(1));

      // Start pulsed mid-run must be ignored
      run_op(id_m, id_v, 96'h0, 1'b1, 1'b0, 3, 1'b0);

      // Reset mid-operation
      @(negedge clk);
      mtx = id_m; vec = id_v; tr = '0; sf = 1'b1; lm = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_done", 128'(done), 128'(0));
      check("mid_rst_outs", 128'({mac_out, ir_out, flags}), 128'(0));
      check("mid_rst_ops", 128'({mac_a, mac_b, mac_c}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      run_op(id_m, id_v, 96'h0, 1'b1, 1'b0, -1, 1'b1);
      // Start accepted in the done cycle
      run_op(m9(16'h1000, 16'h1000, 0, 0, 16'h1000, 0, 0, 0, 16'h1000), id_v,
             {32'h0, 32'h5, 32'h1}, 1'b1, 1'b1, -1, 1'b0);

      for (int n = 0; n < 30; n++) begin
         run_op(rnd_m($urandom_range(0, 1)),
                {16'($urandom()), 16'($urandom()), 16'($urandom())},
                {rnd_tr(), rnd_tr(), rnd_tr()},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT-3)) : -1,
                1'($urandom_range(0, 1)));
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gte_mvmva_seq.md
Name: gte_mvmva_seq

Overview:
- Sequencer for the GTE matrix-vector multiply-accumulate (MVMVA-style): computes MACi = (TRi<<12) + Mi1*V0 + Mi2*V1 + Mi3*V2 for rows i = 1..3.
- Drives the operand side (a, b, c, addsub) of the combinational 27x18 MULTALU and consumes its 48-bit result, one term per cycle.
- Applies the sf shift, MAC overflow detection and IR saturation, then presents MAC1-3, IR1-3 and flags to the GTE register file.

Parameters:
- ACC_W, 48, accumulator/MULTALU result width
- MAC_CHK_W, 44, signed width for MAC overflow check

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin operation; accepted only when busy=0
- sf  in  1  0: no shift; 1: arithmetic shift right by 12
- lm  in  1  1: IR lower clamp is 0
- mtx  in  144  M11..M33, 9x signed 16, M11 in [15:0], row-major
- vec  in  48  V0..V2, 3x signed 16, V0 in [15:0]
- tr  in  96  TR1..TR3, 3x signed 32, TR1 in [31:0]
- mac_a  out  27  to MULTALU a, sign-extended matrix element
- mac_b  out  18  to MULTALU b, sign-extended vector element
- mac_c  out  48  to MULTALU c
- mac_addsub1  out  1  constant 0 (add C)
- mac_addsub0  out  1  constant 0 (add product)
- mac_dout  in  48  MULTALU result, c + a*b, combinational
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: results valid
- mac_out  out  96  MAC1..MAC3, 3x signed 32
- ir_out  out  48  IR1..IR3, 3x signed 16
- flags  out  9  [2:0] mac_pos_ovf, [5:3] mac_neg_ovf, [8:6] ir_sat (bit index = row)

Behaviour:
- Reset: busy=0, done=0, mac_out=0, ir_out=0, flags=0, mac_a/b/c=0, internal state IDLE.
- States: IDLE -> RUN -> IDLE. RUN uses row counter r (0..2) and term counter t (0..2).
- IDLE:
  - start=1 latches mtx, vec, tr, sf, lm; clears flags; resets r=0, t=0; enters RUN; busy=1 from the next cycle.
- RUN, operand drive:
  - mac_a = sext(M[r][t]); mac_b = sext(V[t]).
  - mac_c = sext48(TR[r]<<12) when t=0, otherwise acc.
- RUN, each cycle:
  - acc <= mac_dout.
  - Test mac_dout against signed 44-bit range (bits [47:43] not all equal). On overflow set sticky mac_pos_ovf[r] if bit 47=0, else mac_neg_ovf[r]. Every intermediate sum is checked.
- On t=2 (row final):
  - MACr = (sf ? mac_dout>>>12 : mac_dout)[31:0].
  - IRr = clamp(MACr, lm ? 0 : -0x8000, 0x7FFF). Set ir_sat[r] if clamped.
  - t wraps to 0 and r increments.
- After r=2, t=2 the block returns to IDLE. done=1 for exactly the next cycle (busy=0 that cycle).
- Latency: start sampled at edge E0, terms captured at E1..E9, done high E9-E10.
- mac_out, ir_out and flags hold until the next accepted start. Per-row updates become visible as each row completes.
- start while busy=1: ignored, no effect.
- start asserted in the done cycle: accepted (block is IDLE).
- Reset mid-operation: immediate return to IDLE with all outputs zeroed; partial results discarded.
- MULTALU is combinational, so mac_* are registered outputs of the sequencer.

Optional Feature:
- Macro GTE_MAC_PIPE_EN.
- Defined:
  - mac_dout is registered inside the sequencer; each term takes 2 cycles (issue, capture).
  - Terms captured at E2, E4..E18; done high E18-E19.
  - Operands are held stable across both cycles.
- Undefined: single-cycle terms as above.

Decomposition:
- Package gte_pkg holds:
  - width constants (ACC_W, MAC_CHK_W, IR_W=16)
  - flag bit offsets (MAC_POS_OVF_LSB=0, MAC_NEG_OVF_LSB=3, IR_SAT_LSB=6)
  - IR limits (IR_MAX=0x7FFF, IR_MIN=-0x8000)
  - state enum (IDLE, RUN)
- Sub-module gte_mac_lane: combinational shift + 32-bit truncation + IR clamp/flag for one row. Instantiated once and fed by row r.

Test Plan:
- Identity matrix (diag 0x1000), V=(0x100,0x200,-0x300), TR=0, sf=1, lm=0 -> MAC=(0x100,0x200,-0x300), IR identical, flags=0, done exactly at cycle 10.
- M11=-0x1000, others 0, V0=0x100, sf=1: lm=1 -> MAC1=-0x100, IR1=0, flags[6]=1; lm=0 -> IR1=-0x100, flags=0.
- M11=M12=0x7FFF, V0=V1=0x7FFF, sf=0 -> MAC1=0x7FFE0002, IR1=0x7FFF, flags[6]=1, no MAC overflow.
- TR1=0x7FFFFFFF, M11=V0=0x7FFF, sf=0 -> flags[0]=1 (pos overflow row 0). TR1=0x80000000, M11=0x7FFF, V0=-0x7FFF -> flags[3]=1.
- Pulse start again at cycle 4 of a run -> ignored, single done at cycle 10. Assert reset at cycle 5 -> busy/done/outputs 0; a new start runs cleanly.
- With GTE_MAC_PIPE_EN: identity case -> same results, done at cycle 19.
